// File: rtl/lsu_mem_sequencer_if.sv
// Data-bus handshake between the LSU sequencer (master) and the data memory (slave).
interface lsu_mem_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [3:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  modport master (
    output dreq_valid,
    output dreq_addr,
    output dreq_size,
    output dreq_strobe,
    output dreq_data,
    input  dresp_addr_ok,
    input  dresp_data_ok,
    input  dresp_data
  );

  modport slave (
    input  dreq_valid,
    input  dreq_addr,
    input  dreq_size,
    input  dreq_strobe,
    input  dreq_data,
    output dresp_addr_ok,
    output dresp_data_ok,
    output dresp_data
  );

endinterface

// File: rtl/lsu_mem_sequencer.sv
// MEM-stage load/store sequencer: builds one data-bus request per load/store, stalls the
// pipeline until the bus reports completion and returns the extended load result.
module lsu_mem_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  input  logic [2:0]          ls_flag,
  input  logic                is_store,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   store_data,
  lsu_mem_sequencer_if.master dbus,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   load_data,
  output logic                addr_err
);

  // Load/store kind encoding of ls_flag.
  localparam logic [2:0] LsNone   = 3'd0;
  localparam logic [2:0] LsBtye   = 3'd1;
  localparam logic [2:0] LsBtyeU  = 3'd2;
  localparam logic [2:0] LsHalfw  = 3'd3;
  localparam logic [2:0] LsHalfwU = 3'd4;
  localparam logic [2:0] LsWord   = 3'd5;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e state_q, state_d;

  logic              is_byte, is_half, is_word, misalign, go, latch, capture;
  logic [2:0]        size_n;
  logic [3:0]        strobe_n;
  logic [DATA_W-1:0] data_n;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [3:0]        strobe_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        flag_q;
  logic              store_q;
  logic [1:0]        off_q;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;

  // Decode the incoming access and derive the request fields it would latch.
  always_comb begin
    is_byte  = (ls_flag == LsBtye) || (ls_flag == LsBtyeU);
    is_half  = (ls_flag == LsHalfw) || (ls_flag == LsHalfwU);
    is_word  = (ls_flag == LsWord);
    misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    // Unused flag codes (6, 7) behave like LsNone.
    go       = in_valid && (is_byte || is_half || is_word) && !misalign;
    // stall/addr_err must read 0 while reset is asserted, even with live inputs.
    addr_err = resetn && in_valid && misalign;
    stall    = resetn && go && (state_q != StDone);
    latch    = (state_q == StIdle) && go;

    size_n   = 3'd0;
    strobe_n = 4'b0000;
    data_n   = store_data;
    if (is_half) begin
      size_n = 3'd1;
      data_n = {2{store_data[15:0]}};
      if (is_store) strobe_n = 4'b0011 << addr[1:0];
    end else if (is_word) begin
      size_n = 3'd2;
      data_n = store_data;
      if (is_store) strobe_n = 4'b1111;
    end else begin
      size_n = 3'd0;
      data_n = {4{store_data[7:0]}};
      if (is_store) strobe_n = 4'b0001 << addr[1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; handshake inputs seen in StIdle/StDone are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (go) state_d = StAddr;
      end
      StAddr: begin
        if (dbus.dresp_addr_ok && dbus.dresp_data_ok) begin
          state_d = StDone;
        end else if (dbus.dresp_addr_ok) begin
          state_d = StData;
        end
      end
      StData: begin
        if (dbus.dresp_data_ok) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Latch the request when it leaves StIdle so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      flag_q   <= '0;
      store_q  <= 1'b0;
      off_q    <= '0;
    end else if (latch) begin
      addr_q   <= addr;
      size_q   <= size_n;
      strobe_q <= strobe_n;
      data_q   <= data_n;
      flag_q   <= ls_flag;
      store_q  <= is_store;
      off_q    <= addr[1:0];
    end
  end

  // Align the returned word to the accessed byte and sign/zero-extend it.
  always_comb begin
    shifted = dbus.dresp_data >> {off_q, 3'b000};
    unique case (flag_q)
      LsBtye:   load_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      LsBtyeU:  load_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      LsHalfw:  load_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      LsHalfwU: load_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default:  load_ext = dbus.dresp_data;
    endcase
    // Capture only on the transition that completes a load.
    capture = !store_q &&
              (((state_q == StAddr) && dbus.dresp_addr_ok && dbus.dresp_data_ok) ||
               ((state_q == StData) && dbus.dresp_data_ok));
  end

  // Load result register, held until the next completing load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_data <= '0;
    end else if (capture) begin
      load_data <= load_ext;
    end
  end

  assign done             = (state_q == StDone);
  assign dbus.dreq_valid  = (state_q == StAddr);
  assign dbus.dreq_addr   = addr_q;
  assign dbus.dreq_size   = size_q;
  assign dbus.dreq_strobe = strobe_q;
  assign dbus.dreq_data   = data_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench for lsu_mem_sequencer: directed cases plus randomized accesses
// compared against an arithmetic reference model of the access rules.
module tb_lsu_mem_sequencer;

  localparam logic [2:0] LS_NONE   = 3'd0;
  localparam logic [2:0] LS_BTYE   = 3'd1;
  localparam logic [2:0] LS_BTYE_U = 3'd2;
  localparam logic [2:0] LS_HALFW  = 3'd3;
  localparam logic [2:0] LS_HALFW_U = 3'd4;
  localparam logic [2:0] LS_WORD   = 3'd5;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [2:0]  ls_flag;
  logic        is_store;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        addr_err;

  int n_checks;
  int n_errors;
  logic [31:0] exp_load;

  lsu_mem_sequencer_if dbus ();

  lsu_mem_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .ls_flag    (ls_flag),
    .is_store   (is_store),
    .addr       (addr),
    .store_data (store_data),
    .dbus       (dbus),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned m_bytes(input logic [2:0] f);
    if (f == LS_WORD) return 4;
    if (f == LS_HALFW || f == LS_HALFW_U) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] m_size(input logic [2:0] f);
    int unsigned nb = m_bytes(f);
    return (nb == 4) ? 32'd2 : (nb == 2) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] m_strobe(input logic [2:0] f, input logic st,
                                           input logic [31:0] a);
    int unsigned nb = m_bytes(f);
    int unsigned off = a % 4;
    if (!st) return 32'd0;
    return (((1 << nb) - 1) << off) % 16;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] sd);
    int unsigned nb = m_bytes(f);
    if (nb == 1) return (sd % 256) * 32'h0101_0101;
    if (nb == 2) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned sh = rd >> (8 * (a % 4));
    int unsigned v;
    case (f)
      LS_BTYE: begin
        v = sh % 256;
        if (v >= 128) v = v + 32'hFFFF_FF00;
      end
      LS_BTYE_U: v = sh % 256;
      LS_HALFW: begin
        v = sh % 65536;
        if (v >= 32768) v = v + 32'hFFFF_0000;
      end
      LS_HALFW_U: v = sh % 65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access with a responder that waits la cycles in ADDR before addr_ok and a further
  // ld cycles before data_ok (ld==0: same cycle as addr_ok).
  task automatic do_access(input logic [2:0] flag, input logic st, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int la,
                           input int ld, input bit scramble);
    int n_a, n_d, cyc;
    bit acc, fin;
    n_a = 0; n_d = 0; cyc = 0; acc = 0; fin = 0;
    @(negedge clk);
    dbus.dresp_addr_ok = 1'b0;
    dbus.dresp_data_ok = 1'b0;
    dbus.dresp_data    = rd;
    in_valid   = 1'b1;
    ls_flag    = flag;
    is_store   = st;
    addr       = a;
    store_data = sd;
    #1;
    chk("go_stall", {31'd0, stall}, 32'd1);
    chk("go_addr_err", {31'd0, addr_err}, 32'd0);
    chk("idle_valid", {31'd0, dbus.dreq_valid}, 32'd0);
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        fin = 1;
        if (!st) exp_load = m_load(flag, a, rd);
        chk("done_latency", cyc, la + ld + 2);
        chk("load_data", load_data, exp_load);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_valid", {31'd0, dbus.dreq_valid}, 32'd0);
        in_valid = 1'b0;
        dbus.dresp_addr_ok = 1'b0;
        dbus.dresp_data_ok = 1'b0;
      end else begin
        chk("busy_stall", {31'd0, stall}, 32'd1);
        if (!acc) begin
          chk("addr_valid", {31'd0, dbus.dreq_valid}, 32'd1);
          chk("dreq_addr", dbus.dreq_addr, a);
          chk("dreq_size", {29'd0, dbus.dreq_size}, m_size(flag));
          chk("dreq_strobe", {28'd0, dbus.dreq_strobe}, m_strobe(flag, st, a));
          if (st) chk("dreq_data", dbus.dreq_data, m_wdata(flag, sd));
          n_a++;
          if (scramble && n_a == 1) begin
            addr       = a ^ 32'h0000_0100;
            store_data = ~sd;
          end
          if (n_a > la) begin
            acc = 1;
            dbus.dresp_addr_ok = 1'b1;
            dbus.dresp_data_ok = (ld == 0);
          end
        end else begin
          chk("data_phase_valid", {31'd0, dbus.dreq_valid}, 32'd0);
          dbus.dresp_addr_ok = 1'b0;
          n_d++;
          dbus.dresp_data_ok = (n_d >= ld);
        end
      end
    end
    if (!fin) begin
      n_checks++;
      n_errors++;
      $error("FAIL access_timeout: observed no done expected done within 40 cycles");
      in_valid = 1'b0;
      dbus.dresp_addr_ok = 1'b0;
      dbus.dresp_data_ok = 1'b0;
    end
    @(negedge clk);
    chk("done_once", {31'd0, done}, 32'd0);
    chk("idle_after_valid", {31'd0, dbus.dreq_valid}, 32'd0);
  endtask

  task automatic do_misalign(input logic [2:0] flag, input logic [31:0] a);
    @(negedge clk);
    in_valid = 1'b1; ls_flag = flag; is_store = 1'b0; addr = a; store_data = 32'h0;
    #1;
    repeat (3) begin
      chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      chk("mis_valid", {31'd0, dbus.dreq_valid}, 32'd0);
      chk("mis_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    n_checks = 0;
    n_errors = 0;
    exp_load = 32'h0;
    resetn = 1'b0;
    in_valid = 1'b1; ls_flag = LS_WORD; is_store = 1'b0; addr = 32'h0000_0003;
    store_data = 32'h0;
    dbus.dresp_addr_ok = 1'b0; dbus.dresp_data_ok = 1'b0; dbus.dresp_data = 32'h0;

    // Reset state, with live inputs that would otherwise raise addr_err / stall.
    #3;
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("rst_stall_mis", {31'd0, stall}, 32'd0);
    addr = 32'h0000_0004;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, dbus.dreq_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_load", load_data, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Stray handshakes in IDLE are ignored.
    dbus.dresp_addr_ok = 1'b1; dbus.dresp_data_ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_stray_done", {31'd0, done}, 32'd0);
      chk("idle_stray_valid", {31'd0, dbus.dreq_valid}, 32'd0);
    end
    dbus.dresp_addr_ok = 1'b0; dbus.dresp_data_ok = 1'b0;

    // Directed cases.
    do_access(LS_WORD, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2, 2, 1'b0);
    do_access(LS_BTYE, 1'b0, 32'h8000_0023, 32'h0, 32'h80AA_BBCC, 1, 1, 1'b0);
    do_access(LS_BTYE_U, 1'b0, 32'h8000_0023, 32'h0, 32'h80AA_BBCC, 0, 2, 1'b0);
    do_access(LS_HALFW, 1'b1, 32'h8000_0032, 32'h0000_1234, 32'h0, 1, 1, 1'b0);
    do_access(LS_HALFW, 1'b0, 32'h8000_0042, 32'h0, 32'h9ABC_1234, 0, 0, 1'b0);
    do_access(LS_HALFW_U, 1'b0, 32'h8000_0042, 32'h0, 32'h9ABC_1234, 0, 0, 1'b0);
    do_access(LS_BTYE, 1'b1, 32'h8000_0051, 32'h0000_00A5, 32'h0, 2, 1, 1'b1);
    do_access(LS_WORD, 1'b1, 32'h8000_0060, 32'hCAFE_F00D, 32'h0, 3, 0, 1'b1);
    do_misalign(LS_WORD, 32'h8000_0002);
    do_misalign(LS_HALFW, 32'h8000_0001);
    do_misalign(LS_HALFW_U, 32'h8000_0003);

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(1, 5));
      a = $urandom;
      if (f == LS_HALFW || f == LS_HALFW_U) a[0] = 1'b0;
      if (f == LS_WORD) a[1:0] = 2'b00;
      do_access(f, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    // Reset while in DATA, then a late data_ok.
    @(negedge clk);
    in_valid = 1'b1; ls_flag = LS_WORD; is_store = 1'b0; addr = 32'h8000_0040;
    dbus.dresp_data = 32'h1357_9BDF;
    @(negedge clk);
    dbus.dresp_addr_ok = 1'b1;
    @(negedge clk);
    dbus.dresp_addr_ok = 1'b0;
    chk("pre_rst_data_valid", {31'd0, dbus.dreq_valid}, 32'd0);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, dbus.dreq_valid}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    dbus.dresp_data_ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("late_ok_done", {31'd0, done}, 32'd0);
      chk("late_ok_load", load_data, 32'h0);
    end
    dbus.dresp_data_ok = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
